// File: rtl/div_recombine_if.sv
// Operand/result bundle between the SRT divider's consumer side and div_recombine.
// Signal names follow the divider's vld_i/ready_o handshake so the two blocks line up.
interface div_recombine_if #(
  parameter int WIDTH = 64
);
  logic               vld_i;
  logic [WIDTH-1:0]   op1_i;
  logic [WIDTH-1:0]   op2_i;
  logic [WIDTH-1:0]   quo_i;
  logic [WIDTH-1:0]   rem_i;
  logic               ready_o;
  logic               vld_o;
  logic [2*WIDTH-1:0] prod_o;
  logic               ok_o;
  logic               rng_o;

  modport master (
    output vld_i, op1_i, op2_i, quo_i, rem_i,
    input  ready_o, vld_o, prod_o, ok_o, rng_o
  );

  modport slave (
    input  vld_i, op1_i, op2_i, quo_i, rem_i,
    output ready_o, vld_o, prod_o, ok_o, rng_o
  );
endinterface

// File: rtl/div_recombine.sv
// Radix-4 sequential multiply-add rebuilding quo*op2 + rem from a divider result
// and checking it against the original dividend and divisor.
module div_recombine #(
  parameter int WIDTH = 64
) (
  input  logic           clk,
  input  logic           rstn,
  div_recombine_if.slave bus
);

  localparam int ITER = WIDTH / 2;
  localparam int CW   = $clog2(ITER + 1);
  localparam int PW   = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] op1_q;
  logic [WIDTH-1:0] op2_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_sh;
  logic             quo_ones_q;
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    m1;
  logic [PW-1:0]    m3;
  logic [PW-1:0]    addend;
  logic [WIDTH+1:0] op2x3;
  logic             rng_next;
  logic             ok_next;

  assign op2x3 = {2'b00, bus.op2_i} + {1'b0, bus.op2_i, 1'b0};

  // m1/m3 are pre-shifted by 2k, so the digit only selects a multiple.
  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    addend = '0;
    case (quo_sh[1:0])
      2'd1:    addend = m1;
      2'd2:    addend = m1 << 1;
      2'd3:    addend = m3;
      default: addend = '0;
    endcase
  end

  // A zero divisor follows the divider's convention: quotient all ones, remainder = dividend.
  always_comb begin
    rng_next = 1'b0;
    ok_next  = 1'b0;
    if (op2_q != '0) begin
      rng_next = rem_q < op2_q;
      ok_next  = (acc == {{WIDTH{1'b0}}, op1_q}) && rng_next;
    end else begin
      rng_next = rem_q == op1_q;
      ok_next  = quo_ones_q && (rem_q == op1_q);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: datapath registers are reset too; they are few and it keeps reset-time outputs defined.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      op1_q       <= '0;
      op2_q       <= '0;
      rem_q       <= '0;
      quo_sh      <= '0;
      quo_ones_q  <= 1'b0;
      cnt         <= '0;
      acc         <= '0;
      m1          <= '0;
      m3          <= '0;
      bus.ready_o <= 1'b1;
      bus.vld_o   <= 1'b0;
      bus.prod_o  <= '0;
      bus.ok_o    <= 1'b0;
      bus.rng_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.vld_i) begin
            op1_q       <= bus.op1_i;
            op2_q       <= bus.op2_i;
            rem_q       <= bus.rem_i;
            quo_sh      <= bus.quo_i;
            quo_ones_q  <= &bus.quo_i;
            acc         <= {{WIDTH{1'b0}}, bus.rem_i};
            m1          <= {{WIDTH{1'b0}}, bus.op2_i};
            m3          <= {{(WIDTH-2){1'b0}}, op2x3};
            cnt         <= '0;
            bus.ready_o <= 1'b0;
            state       <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == CW'(ITER)) begin
            bus.prod_o <= acc;
            bus.ok_o   <= ok_next;
            bus.rng_o  <= rng_next;
            bus.vld_o  <= 1'b1;
            state      <= DONE;
          end else begin
            acc    <= acc + addend;
            m1     <= m1 << 2;
            m3     <= m3 << 2;
            quo_sh <= quo_sh >> 2;
            cnt    <= cnt + CW'(1);
          end
        end
        DONE: begin
          bus.vld_o   <= 1'b0;
          bus.ready_o <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          bus.vld_o   <= 1'b0;
          bus.ready_o <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_recombine.sv
// Directed and random checks of div_recombine at WIDTH=64: results, latency, handshake,
// zero-divisor convention, full-width products and asynchronous reset mid-operation.
module tb_div_recombine;

  localparam int W   = 64;
  localparam int LAT = W / 2 + 1;
  localparam int GAP = W / 2 + 3;

  logic clk;
  logic rstn;
  int   total = 0;
  int   bad   = 0;
  int   vld_total = 0;

  div_recombine_if #(.WIDTH(W)) bus ();

  div_recombine #(.WIDTH(W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.vld_o === 1'b1) vld_total++;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  // Entered at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again.
  task automatic run_op(input logic [W-1:0] a, b, q, r,
                        output logic [127:0] p, output logic k, g,
                        output int lat, output logic one_wide, output logic held);
    time t0;
    bus.op1_i = a;
    bus.op2_i = b;
    bus.quo_i = q;
    bus.rem_i = r;
    bus.vld_i = 1'b1;
    @(posedge clk);
    t0 = $time;
    #1;
    bus.vld_i = 1'b0;
    bus.op1_i = ~a;
    bus.op2_i = ~b;
    bus.quo_i = ~q;
    bus.rem_i = ~r;
    lat = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.vld_o === 1'b1) begin
        lat = int'(($time - t0 - 5) / 10);
        break;
      end
    end
    p = bus.prod_o;
    k = bus.ok_o;
    g = bus.rng_o;
    @(negedge clk);
    one_wide = (bus.vld_o === 1'b0) && (bus.ready_o === 1'b1);
    held     = (bus.prod_o === p);
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] a, b, q, r,
                       input logic [127:0] ep, input logic eok, erng);
    logic [127:0] p;
    logic         k, g, ow, hd;
    int           lat;
    check({tag, "_ready"}, 128'(bus.ready_o), 128'(1));
    run_op(a, b, q, r, p, k, g, lat, ow, hd);
    check({tag, "_prod"}, p, ep);
    check({tag, "_ok"}, 128'(k), 128'(eok));
    check({tag, "_rng"}, 128'(g), 128'(erng));
    check({tag, "_lat"}, 128'(lat), 128'(LAT - 1 + 1) - 128'(1) + 128'(1));
    check({tag, "_width"}, 128'(ow), 128'(1));
    check({tag, "_hold"}, 128'(hd), 128'(1));
  endtask

  logic [W-1:0]   ones;
  logic [127:0]   exp_q[$];
  int             cap_c[$];
  int             pulses;
  int             vld_mark;
  logic [W-1:0]   ra, rb, rq, rr;
  logic [127:0]   rp;
  logic           rk, rg, row, rhd;
  int             rlat;

  initial begin
    ones      = '1;
    bus.vld_i = 1'b0;
    bus.op1_i = '0;
    bus.op2_i = '0;
    bus.quo_i = '0;
    bus.rem_i = '0;
    rstn      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 128'(bus.ready_o), 128'(1));
    check("rst_vld", 128'(bus.vld_o), 128'(0));
    check("rst_prod", bus.prod_o, 128'(0));
    check("rst_ok", 128'(bus.ok_o), 128'(0));
    check("rst_rng", 128'(bus.rng_o), 128'(0));
    rstn = 1'b1;
    @(posedge clk);
    #1;

    do_op("good",     64'd59, 64'd13, 64'd4, 64'd7,  128'd59, 1'b1, 1'b1);
    do_op("bad_quo",  64'd59, 64'd13, 64'd5, 64'd7,  128'd72, 1'b0, 1'b1);
    do_op("bad_rem",  64'd59, 64'd13, 64'd3, 64'd20, 128'd59, 1'b0, 1'b0);
    do_op("digit2",   64'd85, 64'd13, 64'd6, 64'd7,  128'd85, 1'b1, 1'b1);
    do_op("zdiv",     64'd17, 64'd0,  ones,  64'd17, 128'd17, 1'b1, 1'b1);
    do_op("zdiv_q0",  64'd17, 64'd0,  64'd0, 64'd17, 128'd17, 1'b0, 1'b1);
    do_op("max_rm2",  64'd0, ones, ones, ones - 64'd1,
          128'hFFFF_FFFF_FFFF_FFFE_FFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    do_op("max_rm1",  64'd0, ones, ones, ones,
          128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000, 1'b0, 1'b0);
    do_op("max_r0",   64'd0, ones, ones, 64'd0,
          128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 1'b0, 1'b1);

    // vld_i held high with fresh operands every cycle; only idle-cycle sets may land.
    pulses = 0;
    for (int c = 0; c < 115; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      bus.op2_i = 64'(7 + c);
      bus.quo_i = 64'(3 * c + 1);
      bus.rem_i = 64'(c);
      bus.op1_i = bus.quo_i * bus.op2_i + bus.rem_i;
      bus.vld_i = 1'b1;
      if (bus.ready_o === 1'b1) begin
        exp_q.push_back(128'(bus.op1_i));
        cap_c.push_back(c);
      end
      @(negedge clk);
      if (bus.vld_o === 1'b1) begin
        pulses++;
        check("stress_pending", 128'(exp_q.size() > 0), 128'(1));
        if (exp_q.size() > 0) check("stress_prod", bus.prod_o, exp_q.pop_front());
        check("stress_ok", 128'(bus.ok_o), 128'(1));
      end
    end
    bus.vld_i = 1'b0;
    for (int n = 0; n < 60 && exp_q.size() > 0; n++) begin
      @(negedge clk);
      if (bus.vld_o === 1'b1) begin
        pulses++;
        check("stress_prod", bus.prod_o, exp_q.pop_front());
        check("stress_ok", 128'(bus.ok_o), 128'(1));
      end
    end
    check("stress_drained", 128'(exp_q.size()), 128'(0));
    check("stress_caps", 128'(cap_c.size()), 128'(4));
    check("stress_pulses", 128'(pulses), 128'(4));
    for (int i = 1; i < cap_c.size(); i++)
      check("stress_gap", 128'(cap_c[i] - cap_c[i-1]), 128'(GAP));
    repeat (3) @(posedge clk);
    #1;

    // Asynchronous reset during iteration 10: outputs clear at once, no result follows.
    bus.op1_i = 64'd200;
    bus.op2_i = 64'd9;
    bus.quo_i = 64'd22;
    bus.rem_i = 64'd2;
    bus.vld_i = 1'b1;
    @(posedge clk);
    #1;
    bus.vld_i = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    vld_mark = vld_total;
    rstn = 1'b0;
    #1;
    check("mrst_ready", 128'(bus.ready_o), 128'(1));
    check("mrst_vld", 128'(bus.vld_o), 128'(0));
    check("mrst_prod", bus.prod_o, 128'(0));
    check("mrst_ok", 128'(bus.ok_o), 128'(0));
    check("mrst_rng", 128'(bus.rng_o), 128'(0));
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    check("mrst_no_vld", 128'(vld_total), 128'(vld_mark));
    do_op("after_rst", 64'd1000, 64'd7, 64'd142, 64'd6, 128'd1000, 1'b1, 1'b1);

    for (int i = 0; i < 1024; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom} >> $urandom_range(63, 0);
      if (rb == '0) rb = 64'd1;
      rq = ra / rb;
      rr = ra % rb;
      run_op(ra, rb, rq, rr, rp, rk, rg, rlat, row, rhd);
      check("rand_prod", rp, 128'(ra));
      check("rand_ok", 128'(rk), 128'(1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
